hams_merge_node: RTL and testbench

- 2-way streaming merge node. Sits directly downstream of the hams sorter.
- Consumes two ascending-sorted runs of pairs, A and B. Each run is delimited by a last flag.
- Emits one ascending merged run at up to 1 pair/cycle.
- Nodes cascade into a merge tree that grows NUM_ELEMENTS-sized sorted blocks into long runs.

---
 rtl/hams_merge_node.sv | 151 +++++++++++++++
 tb/tb_hams_merge_node.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hams_merge_node.sv
// hams_merge_node: 2-way streaming merge of two ascending-sorted runs of pairs.
// Build option: define HAMS_MERGE_CHECK_EN to enable the sticky input order
// checker driving err_unsorted; otherwise err_unsorted is tied to 0.
module hams_merge_node #(
    parameter int unsigned PAIR_W = 96,
    parameter int unsigned KEY_W  = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [PAIR_W-1:0] a_data,
    input  logic              a_last,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [PAIR_W-1:0] b_data,
    input  logic              b_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PAIR_W-1:0] out_data,
    output logic              out_last,
    output logic [CNT_W-1:0]  out_run_len,
    output logic              err_unsorted
);

    typedef enum logic [1:0] {StMerge, StDrainA, StDrainB} state_e;

    state_e            state_q, state_d;
    logic              load;
    logic              a_fire, b_fire;
    logic              a_wins;
    logic              emit_last;
    logic [KEY_W-1:0]  a_key, b_key;
    logic [CNT_W-1:0]  cnt_q;

    // The output register can take a new element when empty or being drained.
    assign load   = ~out_valid | out_ready;
    assign a_key  = a_data[PAIR_W-1 -: KEY_W];
    assign b_key  = b_data[PAIR_W-1 -: KEY_W];
    assign a_wins = (a_key <= b_key);  // ties go to A for stability
    assign a_fire = a_valid & a_ready;
    assign b_fire = b_valid & b_ready;

    // The merged run ends only when the surviving side delivers its last element.
    assign emit_last = ((state_q == StDrainA) && a_fire && a_last) ||
                       ((state_q == StDrainB) && b_fire && b_last);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StMerge;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave MERGE when one side's run ends, return when the other drains
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StMerge: begin
                if (a_fire && a_last) begin
                    state_d = StDrainB;
                end else if (b_fire && b_last) begin
                    state_d = StDrainA;
                end
            end
            StDrainA: if (a_fire && a_last) state_d = StMerge;
            StDrainB: if (b_fire && b_last) state_d = StMerge;
            default:  state_d = StMerge;
        endcase
    end

    // Ready outputs: in MERGE commit only with both heads present
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        unique case (state_q)
            StMerge: begin
                if (a_valid && b_valid && load) begin
                    a_ready = a_wins;
                    b_ready = ~a_wins;
                end
            end
            StDrainA: a_ready = load;
            StDrainB: b_ready = load;
            default: ;
        endcase
    end

    // Output register and run-length counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            out_run_len <= '0;
            cnt_q       <= '0;
        end else if (load) begin
            out_valid <= a_fire | b_fire;
            out_last  <= emit_last;
            if (a_fire) begin
                out_data <= a_data;
            end else if (b_fire) begin
                out_data <= b_data;
            end
            if (a_fire || b_fire) begin
                if (emit_last) begin
                    out_run_len <= cnt_q + 1'b1;
                    cnt_q       <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

`ifdef HAMS_MERGE_CHECK_EN
    logic [KEY_W-1:0] a_prev_q, b_prev_q;
    logic             a_seen_q, b_seen_q;
    logic             err_q;

    // Track the previous accepted key per input; a descent within a run is sticky
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_prev_q <= '0;
            b_prev_q <= '0;
            a_seen_q <= 1'b0;
            b_seen_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (a_fire) begin
                if (a_seen_q && (a_key < a_prev_q)) err_q <= 1'b1;
                a_prev_q <= a_key;
                a_seen_q <= ~a_last;
            end
            if (b_fire) begin
                if (b_seen_q && (b_key < b_prev_q)) err_q <= 1'b1;
                b_prev_q <= b_key;
                b_seen_q <= ~b_last;
            end
        end
    end

    assign err_unsorted = err_q;
`else
    assign err_unsorted = 1'b0;
`endif

endmodule

// File: tb/tb_hams_merge_node.sv
// Self-checking bench for hams_merge_node: queued input drivers, reference
// merge feeding a scoreboard, and a monitor that also checks stall stability.
module tb_hams_merge_node;

    localparam int unsigned PAIR_W = 96;
    localparam int unsigned KEY_W  = 32;
    localparam int unsigned CNT_W  = 16;

    typedef struct packed {
        logic [PAIR_W-1:0] data;
        logic              last;
    } in_t;

    typedef struct packed {
        logic [PAIR_W-1:0] data;
        logic              last;
        logic [CNT_W-1:0]  len;
    } exp_t;

    logic              clk, rst;
    logic              a_valid, a_ready, a_last;
    logic              b_valid, b_ready, b_last;
    logic [PAIR_W-1:0] a_data, b_data;
    logic              out_valid, out_ready, out_last;
    logic [PAIR_W-1:0] out_data;
    logic [CNT_W-1:0]  out_run_len;
    logic              err_unsorted;

    hams_merge_node #(
        .PAIR_W(PAIR_W),
        .KEY_W (KEY_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_data      (a_data),
        .a_last      (a_last),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_data      (b_data),
        .b_last      (b_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_run_len (out_run_len),
        .err_unsorted(err_unsorted)
    );

    in_t         a_q[$];
    in_t         b_q[$];
    exp_t        sb[$];
    int unsigned ra[$];
    int unsigned rb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_out    = 0;
    int unsigned seq_id   = 0;
    bit          rnd_ready = 1'b0;
    bit          gaps      = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue the current ra/rb runs and push their reference merge to the scoreboard.
    task automatic push_run();
        in_t  la[$];
        in_t  lb[$];
        in_t  e;
        exp_t x;
        int   i = 0;
        int   j = 0;
        int   n = ra.size() + rb.size();
        foreach (ra[k]) begin
            e.data = {ra[k], 32'h0, seq_id};
            e.last = (k == ra.size() - 1);
            seq_id++;
            la.push_back(e);
            a_q.push_back(e);
        end
        foreach (rb[k]) begin
            e.data = {rb[k], 32'h0, seq_id};
            e.last = (k == rb.size() - 1);
            seq_id++;
            lb.push_back(e);
            b_q.push_back(e);
        end
        for (int c = 0; c < n; c++) begin
            if (j >= lb.size() ||
                (i < la.size() && la[i].data[PAIR_W-1 -: KEY_W] <= lb[j].data[PAIR_W-1 -: KEY_W]))
            begin
                x.data = la[i].data;
                i++;
            end else begin
                x.data = lb[j].data;
                j++;
            end
            x.last = (c == n - 1);
            x.len  = CNT_W'(n);
            sb.push_back(x);
        end
        ra.delete();
        rb.delete();
    endtask

    task automatic wait_idle(input int budget);
        int cyc = 0;
        while ((sb.size() != 0 || a_q.size() != 0 || b_q.size() != 0) && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk("drain_timeout", {127'h0, sb.size() == 0}, 128'h1);
        repeat (3) @(negedge clk);
    endtask

    // Stream A driver
    initial begin
        bit took;
        a_valid = 1'b0;
        a_data  = '0;
        a_last  = 1'b0;
        forever begin
            @(negedge clk);
            took = a_valid && a_ready && !rst;
            @(posedge clk);
            #1;
            if (took && a_q.size() > 0) void'(a_q.pop_front());
            if (rst || a_q.size() == 0 || (gaps && $urandom_range(0, 3) == 0)) begin
                a_valid = 1'b0;
            end else begin
                a_valid = 1'b1;
                {a_data, a_last} = a_q[0];
            end
        end
    end

    // Stream B driver
    initial begin
        bit took;
        b_valid = 1'b0;
        b_data  = '0;
        b_last  = 1'b0;
        forever begin
            @(negedge clk);
            took = b_valid && b_ready && !rst;
            @(posedge clk);
            #1;
            if (took && b_q.size() > 0) void'(b_q.pop_front());
            if (rst || b_q.size() == 0 || (gaps && $urandom_range(0, 3) == 0)) begin
                b_valid = 1'b0;
            end else begin
                b_valid = 1'b1;
                {b_data, b_last} = b_q[0];
            end
        end
    end

    // Downstream ready: always ready, or ~30% duty when randomised
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    // Monitor: stability under stall, then scoreboard compare on each accept
    initial begin
        bit                stalled = 1'b0;
        logic [PAIR_W-1:0] held_data;
        logic              held_last;
        exp_t              e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
                continue;
            end
            if (stalled) begin
                chk("hold_valid", {127'h0, out_valid}, 128'h1);
                chk("hold_data", out_data, held_data);
                chk("hold_last", {127'h0, out_last}, {127'h0, held_last});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", {127'h0, out_valid}, 128'h0);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_last", {127'h0, out_last}, {127'h0, e.last});
                    if (e.last) chk("out_run_len", out_run_len, e.len);
                    n_out++;
                end
            end
            stalled   = out_valid && !out_ready;
            held_data = out_data;
            held_last = out_last;
        end
    end

    initial begin
        int          t0;
        int          cyc;
        int unsigned k;
        logic        err_exp;

`ifdef HAMS_MERGE_CHECK_EN
        err_exp = 1'b1;
`else
        err_exp = 1'b0;
`endif

        // Reset state
        rst = 1'b1;
        #1;
        chk("rst_out_valid", {127'h0, out_valid}, 128'h0);
        chk("rst_out_data", out_data, 128'h0);
        chk("rst_out_last", {127'h0, out_last}, 128'h0);
        chk("rst_run_len", out_run_len, 128'h0);
        chk("rst_err", {127'h0, err_unsorted}, 128'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic merge, with back-to-back throughput check
        ra = '{1, 4, 7, 9};
        rb = '{2, 3, 8, 10};
        t0 = n_out;
        push_run();
        cyc = 0;
        while (n_out == t0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        cyc = 0;
        while (n_out < t0 + 8 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("basic_back_to_back", cyc, 7);
        wait_idle(100);

        // Tie stability: A0, A1, then B2
        seq_id = 0;
        ra = '{5, 5};
        rb = '{5};
        push_run();
        wait_idle(100);

        // Drain path and single-element runs, then a fresh two-element run
        ra = '{100};
        rb = '{1, 2, 3};
        push_run();
        ra = '{6};
        rb = '{5};
        push_run();
        wait_idle(100);

        // Backpressure and input gaps over random sorted runs
        rnd_ready = 1'b1;
        gaps      = 1'b1;
        for (int r = 0; r < 200; r++) begin
            k = $urandom_range(0, 20);
            for (int i = 0; i < $urandom_range(1, 16); i++) begin
                k += $urandom_range(0, 3);
                ra.push_back(k);
            end
            k = $urandom_range(0, 20);
            for (int i = 0; i < $urandom_range(1, 16); i++) begin
                k += $urandom_range(0, 3);
                rb.push_back(k);
            end
            push_run();
        end
        wait_idle(40000);
        rnd_ready = 1'b0;
        gaps      = 1'b0;
        chk("err_after_sorted", {127'h0, err_unsorted}, 128'h0);

        // Asynchronous reset mid-run after 3 of 8 outputs
        ra = '{10, 20, 30, 40};
        rb = '{15, 25, 35, 45};
        t0 = n_out;
        push_run();
        cyc = 0;
        while (n_out < t0 + 3 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("pre_reset_progress", n_out - t0, 3);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", {127'h0, out_valid}, 128'h0);
        chk("midrst_out_last", {127'h0, out_last}, 128'h0);
        chk("midrst_run_len", out_run_len, 128'h0);
        a_q.delete();
        b_q.delete();
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        ra = '{7};
        rb = '{3, 9};
        push_run();
        wait_idle(100);

        // Order checker: A run descends 3 -> 2
        ra = '{3, 2};
        rb = '{10};
        push_run();
        wait_idle(100);
        chk("err_unsorted_set", {127'h0, err_unsorted}, {127'h0, err_exp});
        repeat (5) @(negedge clk);
        chk("err_unsorted_sticky", {127'h0, err_unsorted}, {127'h0, err_exp});
        rst = 1'b1;
        #1;
        chk("err_unsorted_cleared", {127'h0, err_unsorted}, 128'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
